fifo_wr_ptr_full: RTL and testbench

Write-domain pointer and status generator for the asynchronous FIFO. It maintains the binary write pointer, addresses the dual-port RAM, and publishes a registered Gray-coded write pointer that the two-flop synchronizer carries into the read domain. It compares the read pointer, already synchronized into the write domain, against its own pointer to produce full, almost-full, a fill level and a sticky overflow flag.

---
 rtl/fifo_wr_ptr_full.sv | 76 +++++++
 tb/tb_fifo_wr_ptr_full.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer/status block of the async FIFO: binary write pointer,
// registered Gray pointer for the synchronizer, full/almost-full/level/overflow.
module fifo_wr_ptr_full #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned AF_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc_i,
  input  logic [ADDR_W:0]   rptr_sync_i,
  input  logic              ovf_clr_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W:0]   wptr_gray_o,
  output logic              wfull_o,
  output logic              walmost_full_o,
  output logic [ADDR_W:0]   wlevel_o,
  output logic              overflow_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_THRESH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             wfull_q, wfull_d;
  logic             waf_q, waf_d;
  logic             ovf_q, ovf_d;
  logic             wen_c;
  logic [PTR_W-1:0] rbin_c;
  logic [PTR_W-1:0] rptr_full_c;

  // Next pointer and all status, recomputed every clock from the pointer and rptr_sync_i
  always_comb begin
    wen_c       = winc_i & ~wfull_q;
    wbin_d      = wbin_q + PTR_W'(wen_c);
    wgray_d     = wbin_d ^ (wbin_d >> 1);
    rbin_c      = '0;
    for (int i = 0; i < PTR_W; i++) begin
      rbin_c[i] = ^(rptr_sync_i >> i);
    end
    // Full when pointers match except for the two Gray MSBs
    rptr_full_c = {~rptr_sync_i[ADDR_W -: 2], rptr_sync_i[ADDR_W-2:0]};
    wfull_d     = (wgray_d == rptr_full_c);
    wlevel_d    = wbin_d - rbin_c;
    waf_d       = (wlevel_d >= AF_LEVEL);
    ovf_d       = (winc_i & wfull_q) | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr_o        = wbin_q[ADDR_W-1:0];
  assign wptr_gray_o    = wgray_q;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = waf_q;
  assign wlevel_o       = wlevel_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Scoreboard bench for fifo_wr_ptr_full: a behavioural model queues expected
// outputs as stimulus is driven; each scenario pops and compares after the edge.
module tb_fifo_wr_ptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [5:0] rptr_sync;
  logic       ovf_clr;
  logic [4:0] waddr;
  logic [5:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [5:0] wlevel;
  logic       overflow;

  typedef struct packed {
    logic [4:0] waddr;
    logic [5:0] gray;
    logic       full;
    logic       af;
    logic [5:0] level;
    logic       ovf;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp, prev;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state
  logic [5:0] m_wbin;
  logic [5:0] m_rbin;
  logic       m_full;
  logic       m_ovf;

  fifo_wr_ptr_full #(.ADDR_W(5), .AF_THRESH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .winc_i        (winc),
    .rptr_sync_i   (rptr_sync),
    .ovf_clr_i     (ovf_clr),
    .waddr_o       (waddr),
    .wptr_gray_o   (wptr_gray),
    .wfull_o       (wfull),
    .walmost_full_o(walmost_full),
    .wlevel_o      (wlevel),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] from_gray(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{waddr: waddr, gray: wptr_gray, full: wfull, af: walmost_full,
          level: wlevel, ovf: overflow};
    return o;
  endfunction

  task automatic model_reset();
    m_wbin = '0;
    m_rbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  // Drive one clock of stimulus, queue the model's prediction, return at posedge+1
  task automatic step(input logic w, input logic [5:0] rp, input logic clr);
    logic [5:0] nb, lvl;
    obs_t e;
    nb  = m_wbin + ((w && !m_full) ? 6'd1 : 6'd0);
    lvl = nb - from_gray(rp);
    e.waddr = nb[4:0];
    e.gray  = to_gray(nb);
    e.level = lvl;
    e.full  = (lvl == 6'd32);
    e.af    = (32 - int'(lvl)) <= 4;
    e.ovf   = (w && m_full) || (m_ovf && !clr);
    sb.push_back(e);
    m_wbin = nb;
    m_full = e.full;
    m_ovf  = e.ovf;
    winc = w; rptr_sync = rp; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    winc = 0; ovf_clr = 0; rptr_sync = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    got = sample();
    n_checks++;
    if (got !== obs_t'(0)) $display("FAIL reset_initial got=%h want=0", got);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 6'd0, 1'b0);
      got = sample(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL reset_prewrite%0d got=%h want=%h", i, got, exp);
      else n_pass++;
    end
    #3 rst = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== obs_t'(0)) $display("FAIL reset_async got=%h want=0", got);
    else n_pass++;
    model_reset();
    winc = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 6'd0, 1'b0);
    got = sample(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || got.waddr !== 5'd1 || got.gray !== 6'b000001)
      $display("FAIL reset_first_write got=%h want=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 6'd0, 1'b0);
      got = sample(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL fill_w%0d got=%h want=%h", i, got, exp);
      else n_pass++;
      if (i == 27 || i == 28) begin
        n_checks++;
        if (got.af !== (i == 28)) $display("FAIL fill_af_w%0d got=%b want=%b", i, got.af, i == 28);
        else n_pass++;
      end
    end
    n_checks++;
    if (got.full !== 1'b1 || got.gray !== 6'b110000 || got.level !== 6'd32)
      $display("FAIL fill_full got full=%b gray=%b lvl=%0d want 1/110000/32",
               got.full, got.gray, got.level);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'd0, 1'b0);
      got = sample(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp || got.gray !== 6'b110000 || got.waddr !== 5'd0 || got.ovf !== 1'b1)
        $display("FAIL ovf_hold%0d got=%h want=%h", i, got, exp);
      else n_pass++;
    end
    step(1'b0, 6'd0, 1'b1);
    got = sample(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || got.ovf !== 1'b0) $display("FAIL ovf_clear got=%h want=%h", got, exp);
    else n_pass++;
    step(1'b1, 6'd0, 1'b1);
    got = sample(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || got.ovf !== 1'b1) $display("FAIL ovf_set_wins got=%h want=%h", got, exp);
    else n_pass++;
    step(1'b0, 6'd0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_release();
    step(1'b0, 6'b000001, 1'b0);
    got = sample(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || got.full !== 1'b0 || got.level !== 6'd31 || got.af !== 1'b1)
      $display("FAIL release_1 got=%h want=%h", got, exp);
    else n_pass++;
    step(1'b0, 6'b000111, 1'b0);
    got = sample(); exp = sb.pop_front();
    n_checks++;
    if (got !== exp || got.level !== 6'd27 || got.af !== 1'b0)
      $display("FAIL release_5 got=%h want=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [5:0] rp;
    do_reset();
    prev = sample();
    for (int i = 1; i <= 64; i++) begin
      rp = (i >= 2) ? to_gray(6'(i - 2)) : 6'd0;
      step(1'b1, rp, 1'b0);
      got = sample(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp || $countones(got.gray ^ prev.gray) != 1 || got.full !== 1'b0 ||
          (i >= 2 && got.level !== 6'd2))
        $display("FAIL wrap_w%0d got=%h want=%h prev_gray=%b", i, got, exp, prev.gray);
      else n_pass++;
      prev = got;
    end
    n_checks++;
    if (got.gray !== 6'd0 || got.waddr !== 5'd0)
      $display("FAIL wrap_end got gray=%b waddr=%0d want 0/0", got.gray, got.waddr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic w;
    do_reset();
    prev = sample();
    for (int i = 0; i < 1500; i++) begin
      w = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && m_rbin != m_wbin) m_rbin = m_rbin + 6'd1;
      step(w, to_gray(m_rbin), ($urandom_range(0, 15) == 0));
      got = sample(); exp = sb.pop_front();
      n_checks++;
      if (got !== exp || got.level > 6'd32 || got.full !== (got.level == 6'd32) ||
          (prev.full && got.gray !== prev.gray))
        $display("FAIL random_c%0d got=%h want=%h", i, got, exp);
      else n_pass++;
      prev = got;
    end
  endtask

  initial begin
    rst = 1'b0; winc = 0; ovf_clr = 0; rptr_sync = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
